// File: rtl/ap_host_pkg.sv
// Shared types and helpers for the ap_ctrl_hs host initiator.
package ap_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_RESULT
  } state_t;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ap_host_ctrl_watchdog.sv
// Kernel watchdog: counts enabled cycles after a clear and flags expiry
// in the cycle that would reach TIMEOUT. Saturates instead of wrapping.
module ap_watchdog
  import ap_host_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WW = clog2(TIMEOUT);

  logic [WW-1:0] wd;

  assign expired = enable && (wd == WW'(TIMEOUT - 1));

  // Cycle counter, restarted on clear, frozen once expiry is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       wd <= '0;
    else if (clear)                wd <= '0;
    else if (enable && !expired)   wd <= wd + WW'(1);
  end

endmodule

// File: rtl/ap_host_ctrl.sv
// Host-side initiator for an ap_ctrl_hs kernel with two SRAM array ports:
// loads a/b, starts the kernel, waits for done (with watchdog) and
// returns ap_return over a valid/ready result handshake.
module ap_host_ctrl
  import ap_host_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          cmd_start,
  input  logic [AW-1:0] cmd_n,
  output logic          busy,
  output logic          err,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_a,
  input  logic [DW-1:0] load_b,
  output logic [AW-1:0] sram_address,
  output logic [DW-1:0] sram_a_d,
  output logic [DW-1:0] sram_b_d,
  output logic          sram_we,
  output logic          mux_sel,
  output logic          ap_start,
  input  logic          ap_done,
  input  logic          ap_idle,
  input  logic [DW-1:0] ap_return,
  output logic [AW-1:0] k_n,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data
);

  localparam int CW = clog2(DEPTH + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] n, n_nxt, cnt, cnt_nxt;
  logic          busy_nxt, err_nxt, we_nxt, mux_nxt, start_nxt, rv_nxt;
  logic [AW-1:0] addr_nxt, kn_nxt;
  logic [DW-1:0] a_d_nxt, b_d_nxt, rd_nxt;
  logic          accept, cmd_legal, wd_clear, wd_en, wd_expired;

  // ap_idle is informational only; the handshake relies on ap_done.
  logic unused_idle;
  assign unused_idle = ap_idle;

  assign load_ready = (state == S_LOAD);
  assign accept     = load_valid && load_ready;
  assign cmd_legal  = (cmd_n != '0) && (cmd_n <= AW'(DEPTH));
  assign wd_en      = (state == S_RUN) && !ap_done;

  ap_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    err_nxt   = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = sram_address;
    a_d_nxt   = sram_a_d;
    b_d_nxt   = sram_b_d;
    mux_nxt   = mux_sel;
    start_nxt = ap_start;
    kn_nxt    = k_n;
    rv_nxt    = res_valid;
    rd_nxt    = res_data;
    wd_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          if (cmd_legal) begin
            n_nxt     = cmd_n[CW-1:0];
            cnt_nxt   = '0;
            busy_nxt  = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_nxt   = 1'b1;
          addr_nxt = AW'(cnt);
          a_d_nxt  = load_a;
          b_d_nxt  = load_b;
          cnt_nxt  = cnt + CW'(1);
          if (cnt == n - CW'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last host write lands this cycle; hand the SRAMs over on exit.
        mux_nxt   = 1'b1;
        kn_nxt    = AW'(n);
        start_nxt = 1'b1;
        wd_clear  = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ap_done) begin
          rd_nxt    = ap_return;
          start_nxt = 1'b0;
          rv_nxt    = 1'b1;
          state_nxt = S_RESULT;
        end else if (wd_expired) begin
          err_nxt   = 1'b1;
          start_nxt = 1'b0;
          mux_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          rv_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          mux_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state        <= S_IDLE;
      n            <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      sram_we      <= 1'b0;
      sram_address <= '0;
      sram_a_d     <= '0;
      sram_b_d     <= '0;
      mux_sel      <= 1'b0;
      ap_start     <= 1'b0;
      k_n          <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      state        <= state_nxt;
      n            <= n_nxt;
      cnt          <= cnt_nxt;
      busy         <= busy_nxt;
      err          <= err_nxt;
      sram_we      <= we_nxt;
      sram_address <= addr_nxt;
      sram_a_d     <= a_d_nxt;
      sram_b_d     <= b_d_nxt;
      mux_sel      <= mux_nxt;
      ap_start     <= start_nxt;
      k_n          <= kn_nxt;
      res_valid    <= rv_nxt;
      res_data     <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_ap_host_ctrl.sv
// Bench for ap_host_ctrl with a behavioural dotprod kernel and SRAM model.
module tb_ap_host_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 16;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic [AW-1:0] cmd_n = '0;
  logic          busy, err;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_a = '0, load_b = '0;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_a_d, sram_b_d;
  logic          sram_we, mux_sel, ap_start;
  logic          ap_done = 1'b0;
  logic          ap_idle = 1'b1;
  logic [DW-1:0] ap_return = '0;
  logic [AW-1:0] k_n;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;

  ap_host_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(clk), .ap_rst(ap_rst), .cmd_start(cmd_start), .cmd_n(cmd_n),
    .busy(busy), .err(err), .load_valid(load_valid), .load_ready(load_ready),
    .load_a(load_a), .load_b(load_b), .sram_address(sram_address),
    .sram_a_d(sram_a_d), .sram_b_d(sram_b_d), .sram_we(sram_we),
    .mux_sel(mux_sel), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_return(ap_return), .k_n(k_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int addr; logic [DW-1:0] a; logic [DW-1:0] b; } wr_t;
  typedef struct { int n; int a0; int b0; bit toggle; bit exp_err; logic [DW-1:0] exp_res; } vec_t;

  wr_t           wq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] mem_a[DEPTH];
  logic [DW-1:0] mem_b[DEPTH];
  wr_t           w;

  // SRAM model plus write scoreboard.
  always @(negedge clk) begin
    if (!ap_rst && sram_we) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got sram_we=1 addr=%0d expected no write", sram_address);
      end else begin
        w = wq.pop_front();
        check("wr_addr", 64'(sram_address), 64'(w.addr));
        check("wr_a", 64'(sram_a_d), 64'(w.a));
        check("wr_b", 64'(sram_b_d), 64'(w.b));
        check("wr_host_owns", 64'(mux_sel), 64'd0);
      end
      if (sram_address < DEPTH) begin
        mem_a[sram_address[3:0]] = sram_a_d;
        mem_b[sram_address[3:0]] = sram_b_d;
      end
    end
  end

  // Behavioural dotprod kernel.
  int            klat = 3;
  bit            k_hang = 1'b0;
  int            kcnt = 0;
  logic [DW-1:0] dot;
  always @(negedge clk) begin
    ap_idle = !ap_start;
    if (ap_rst || !ap_start) begin
      kcnt = 0;
      ap_done = 1'b0;
    end else if (ap_done) begin
      ap_done = 1'b0;
    end else begin
      kcnt++;
      if (!k_hang && kcnt >= klat) begin
        dot = '0;
        for (int j = 0; j < DEPTH; j++)
          if (j < int'(k_n)) dot = dot + mem_a[j] * mem_b[j];
        ap_return = dot;
        ap_done = 1'b1;
        check("kernel_owns_sram", 64'(mux_sel), 64'd1);
      end
    end
  end

  task automatic start_cmd(input int n);
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_n = AW'(n);
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic load_all(input int n, input int a0, input int b0, input bit toggle);
    int i = 0;
    int cyc = 0;
    bit v;
    check("load_ready_latency", 64'(load_ready), 64'd1);
    check("busy_on_start", 64'(busy), 64'd1);
    while (i < n && cyc < 200) begin
      v = !toggle || (cyc % 2 == 0);
      load_valid = v;
      load_a = v ? DW'(a0 + i) : 32'hdead_beef;
      load_b = v ? DW'(b0 - i) : 32'hbad0_f00d;
      if (v && load_ready) begin
        wq.push_back('{i, DW'(a0 + i), DW'(b0 - i)});
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    load_valid = 1'b0;
    check("load_count", 64'(i), 64'(n));
    check("drain_ready", 64'(load_ready), 64'd0);
    check("drain_start", {ap_start, mux_sel}, 64'd0);
    @(negedge clk);
    check("run_start", {ap_start, mux_sel}, 64'd3);
    check("run_k_n", 64'(k_n), 64'(n));
  endtask

  task automatic wait_valid();
    logic [DW-1:0] exp;
    int t = 0;
    while (!res_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_seen", 64'(res_valid), 64'd1);
    exp = (rq.size() > 0) ? rq.pop_front() : 'x;
    check("res_data", 64'(res_data), 64'(exp));
    check("res_state", {ap_start, mux_sel, busy}, 64'd3);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_hs", {res_valid, busy, mux_sel}, 64'd0);
    check("writes_drained", 64'(wq.size()), 64'd0);
  endtask

  vec_t tbl[7];
  int   cnt;
  logic [DW-1:0] held;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{10, 1, 10, 1'b0, 1'b0, 32'd220};
    tbl[1] = '{0, 0, 0, 1'b0, 1'b1, 32'd0};
    tbl[2] = '{17, 0, 0, 1'b0, 1'b1, 32'd0};
    tbl[3] = '{1, 7, 6, 1'b0, 1'b0, 32'd42};
    tbl[4] = '{10, 1, 10, 1'b1, 1'b0, 32'd220};
    tbl[5] = '{3, 5, 9, 1'b1, 1'b0, 32'd142};
    tbl[6] = '{16, 2, 20, 1'b0, 1'b0, 32'd1560};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, err, load_ready, sram_we, mux_sel, ap_start, res_valid}, 64'd0);
    check("rst_data", {k_n, res_data}, 64'd0);
    ap_rst = 1'b0;

    // Table-driven jobs.
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].exp_err) begin
        start_cmd(tbl[v].n);
        check("err_pulse", 64'(err), 64'd1);
        check("err_idle", {busy, load_ready, sram_we}, 64'd0);
        @(negedge clk);
        check("err_one_cycle", {err, busy}, 64'd0);
      end else begin
        rq.push_back(tbl[v].exp_res);
        start_cmd(tbl[v].n);
        load_all(tbl[v].n, tbl[v].a0, tbl[v].b0, tbl[v].toggle);
        wait_valid();
        handshake();
      end
    end

    // Kernel never completes: watchdog abort.
    k_hang = 1'b1;
    start_cmd(2);
    load_all(2, 3, 4, 1'b0);
    cnt = 1;
    while (ap_start && cnt < TIMEOUT + 50) begin
      @(negedge clk);
      if (ap_start) cnt++;
    end
    check("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_state", {ap_start, mux_sel, busy, load_ready}, 64'd0);
    @(negedge clk);
    check("timeout_err_pulse", 64'(err), 64'd0);
    k_hang = 1'b0;

    // Result held while res_ready stays low; cmd_start ignored meanwhile.
    rq.push_back(32'd60);
    start_cmd(4);
    load_all(4, 1, 8, 1'b0);
    wait_valid();
    held = res_data;
    for (int k = 0; k < 5; k++) begin
      cmd_start = (k == 1);
      cmd_n = 3;
      check("stall_valid", 64'(res_valid), 64'd1);
      check("stall_data", 64'(res_data), 64'd60);
      check("stall_stable", 64'(res_data), 64'(held));
      check("stall_ctrl", {busy, load_ready, err}, 64'd4);
      @(negedge clk);
    end
    cmd_start = 1'b0;
    handshake();
    @(negedge clk);
    check("ignored_cmd", {busy, load_ready, err}, 64'd0);

    // Reset pulsed during RUN, then a fresh job.
    klat = 30;
    start_cmd(5);
    load_all(5, 1, 1, 1'b0);
    repeat (3) @(negedge clk);
    #2 ap_rst = 1'b1;
    #1 check("rst_mid_run", {ap_start, mux_sel, busy}, 64'd0);
    @(negedge clk);
    ap_rst = 1'b0;
    klat = 3;
    rq.push_back(32'd220);
    start_cmd(10);
    load_all(10, 1, 10, 1'b0);
    wait_valid();
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
